sync_pattern_gen: RTL and testbench

- Upstream stimulus source for the sync-pulse tester: generates the 4 MHz microsecond-class strobe `tus` and the 16-bit sync bus `o[15:0]`. `o[15:0]` feeds the tester's `i[15:0]` input directly.
- Emits a repeating frame of TNI/TKI/TNP/TKP/TNC/TNO pulses with programmable offsets and widths.
- Used for bench self-test of the board and for lab stimulus when the real sync source is absent.

---
 rtl/sync_pkg.sv | 35 +++
 rtl/sync_pulse_win.sv | 35 +++
 rtl/sync_pattern_gen.sv | 205 ++++++++++++++++++++
 tb/tb_sync_pattern_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and types for the sync pattern generator: sync-bus bit map,
// FSM state encoding and the per-frame shadow configuration.
package sync_pkg;

    localparam int BIT_TNI = 15;
    localparam int BIT_TKI = 13;
    localparam int BIT_TNP = 10;
    localparam int BIT_TKP = 9;
    localparam int BIT_TNC = 6;
    localparam int BIT_TNO = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] frame_len;
        logic [15:0] i_w;
        logic [15:0] ki_off;
        logic [15:0] ki_w;
        logic [15:0] p_off;
        logic [15:0] p_w;
        logic [15:0] kp_off;
        logic [15:0] kp_w;
        logic [15:0] nc_w;
        logic [15:0] no_w;
    } shadow_cfg_t;

    // A frame shorter than two ticks would never produce a falling edge.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len < 32'd2) ? 32'd2 : len;
    endfunction

endpackage

// File: rtl/sync_pulse_win.sv
// One pulse-window bit: high for tick t in [off, off+w) inside the frame,
// registered so the bit changes on the same edge as the tick strobe.
module sync_pulse_win
    import sync_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [31:0] t_i,
    input  logic [31:0] len_i,
    input  logic [15:0] off_i,
    input  logic [15:0] w_i,
    output logic        q_o
);

    logic [32:0] t_x;
    logic [32:0] off_x;
    logic [32:0] end_x;
    logic        hit;
    logic        q_q;

    // 33-bit compare so off+w can never wrap.
    assign t_x   = {1'b0, t_i};
    assign off_x = {17'b0, off_i};
    assign end_x = off_x + {17'b0, w_i};
    assign hit   = en_i && (t_x >= off_x) && (t_x < end_x) && (t_i < len_i);

    always_ff @(posedge clk) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= hit;
    end

    assign q_o = q_q;

endmodule

// File: rtl/sync_pattern_gen.sv
// Sync-pulse stimulus generator: tus tick strobe plus a repeating TNI/TKI/TNP/TKP/TNC/TNO
// frame on o[15:0]. Define SYNC_FAULT_INJ_EN to add the inj fault-injection input.
module sync_pattern_gen
    import sync_pkg::*;
#(
    parameter int CLK_PER_TICK = 25,
    parameter int SEC_FRAMES_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [31:0]             cfg_frame_len,
    input  logic [15:0]             cfg_i_w,
    input  logic [15:0]             cfg_ki_off,
    input  logic [15:0]             cfg_ki_w,
    input  logic [15:0]             cfg_p_off,
    input  logic [15:0]             cfg_p_w,
    input  logic [15:0]             cfg_kp_off,
    input  logic [15:0]             cfg_kp_w,
    input  logic [15:0]             cfg_nc_w,
    input  logic [SEC_FRAMES_W-1:0] cfg_sec_frames,
    input  logic [15:0]             cfg_no_w,
`ifdef SYNC_FAULT_INJ_EN
    input  logic [1:0]              inj,
`endif
    output logic                    tus,
    output logic [15:0]             o,
    output logic                    busy,
    output logic [31:0]             frame_cnt
);

    localparam int NWIN = 6;
    localparam int PW   = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;

    logic [PW-1:0]           presc_q, presc_d;
    logic                    tus_q;
    logic                    tick;
    state_e                  state_q, state_d;
    logic [31:0]             t_q, t_d;
    shadow_cfg_t             cfg_q, cfg_d, cfg_in;
    logic [SEC_FRAMES_W-1:0] sec_q, sec_d, sec_eff;
    logic [SEC_FRAMES_W-1:0] div_q, div_d;
    logic [31:0]             fc_q, fc_d;
    logic                    latch;
    logic                    run_d;

    logic [NWIN-1:0]             win_en;
    logic [NWIN-1:0][31:0]       win_t;
    logic [NWIN-1:0][15:0]       win_off;
    logic [NWIN-1:0][15:0]       win_w;
    logic [NWIN-1:0]             win_q;

`ifdef SYNC_FAULT_INJ_EN
    logic [1:0] inj_q, inj_d;
    logic       inj_p_q, inj_p_hit;
`endif

    // tick fires one clk early so tus is registered and lands on prescaler == CLK_PER_TICK-1.
    assign presc_d = (presc_q == PW'(CLK_PER_TICK - 1)) ? '0 : presc_q + PW'(1);
    assign tick    = (presc_q == PW'(CLK_PER_TICK - 2));
    assign sec_eff = (sec_q == '0) ? SEC_FRAMES_W'(1) : sec_q;

    always_comb begin
        cfg_in           = '0;
        cfg_in.frame_len = clamp_len(cfg_frame_len);
        cfg_in.i_w       = cfg_i_w;
        cfg_in.ki_off    = cfg_ki_off;
        cfg_in.ki_w      = cfg_ki_w;
        cfg_in.p_off     = cfg_p_off;
        cfg_in.p_w       = cfg_p_w;
        cfg_in.kp_off    = cfg_kp_off;
        cfg_in.kp_w      = cfg_kp_w;
        cfg_in.nc_w      = cfg_nc_w;
        cfg_in.no_w      = cfg_no_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tus_q   <= 1'b0;
            state_q <= IDLE;
            t_q     <= '0;
            cfg_q   <= '0;
            sec_q   <= '0;
            div_q   <= '0;
            fc_q    <= '0;
`ifdef SYNC_FAULT_INJ_EN
            inj_q   <= '0;
`endif
        end else begin
            presc_q <= presc_d;
            tus_q   <= tick;
            state_q <= state_d;
            t_q     <= t_d;
            cfg_q   <= cfg_d;
            sec_q   <= sec_d;
            div_q   <= div_d;
            fc_q    <= fc_d;
`ifdef SYNC_FAULT_INJ_EN
            inj_q   <= inj_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        cfg_d   = cfg_q;
        sec_d   = sec_q;
        div_d   = div_q;
        fc_d    = fc_q;
        latch   = 1'b0;
`ifdef SYNC_FAULT_INJ_EN
        inj_d   = inj_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tick && en) begin
                    state_d = RUN;
                    t_d     = '0;
                    latch   = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    if (t_q >= cfg_q.frame_len - 32'd1) begin
                        fc_d = fc_q + 32'd1;
                        if (en) begin
                            t_d   = '0;
                            latch = 1'b1;
                            div_d = (div_q >= sec_eff - SEC_FRAMES_W'(1)) ? '0 : div_q + SEC_FRAMES_W'(1);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        t_d = t_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (latch) begin
            cfg_d = cfg_in;
            sec_d = cfg_sec_frames;
`ifdef SYNC_FAULT_INJ_EN
            inj_d = inj;
`endif
        end
    end

    // Windows see next-state tick/config so their registered outputs move with tus.
    always_comb begin
        run_d      = (state_d == RUN);
        win_en     = {NWIN{run_d}};
        win_en[5]  = run_d && (div_d == '0);
        win_t      = {NWIN{t_d}};
`ifdef SYNC_FAULT_INJ_EN
        if (inj_d[1]) win_t[4] = {30'b0, t_d[1:0]};
`endif
        win_off    = {16'd0, 16'd0, cfg_d.kp_off, cfg_d.p_off, cfg_d.ki_off, 16'd0};
        win_w      = {cfg_d.no_w, cfg_d.nc_w, cfg_d.kp_w, cfg_d.p_w, cfg_d.ki_w, cfg_d.i_w};
    end

    for (genvar g = 0; g < NWIN; g++) begin : g_win
        sync_pulse_win u_win (
            .clk   (clk),
            .rst   (rst),
            .en_i  (win_en[g]),
            .t_i   (win_t[g]),
            .len_i (cfg_d.frame_len),
            .off_i (win_off[g]),
            .w_i   (win_w[g]),
            .q_o   (win_q[g])
        );
    end

`ifdef SYNC_FAULT_INJ_EN
    // TNP held high across the whole TNI..TKI-end span to force an I/P overlap.
    assign inj_p_hit = run_d && inj_d[0] &&
                       ({1'b0, t_d} < ({17'b0, cfg_d.ki_off} + {17'b0, cfg_d.ki_w}));

    always_ff @(posedge clk) begin
        if (rst) inj_p_q <= 1'b0;
        else     inj_p_q <= inj_p_hit;
    end
`endif

    always_comb begin
        o            = '0;
        o[BIT_TNI]   = win_q[0];
        o[BIT_TKI]   = win_q[1];
`ifdef SYNC_FAULT_INJ_EN
        o[BIT_TNP]   = win_q[2] | inj_p_q;
`else
        o[BIT_TNP]   = win_q[2];
`endif
        o[BIT_TKP]   = win_q[3];
        o[BIT_TNC]   = win_q[4];
        o[BIT_TNO]   = win_q[5];
        tus          = tus_q;
        busy         = (state_q == RUN);
        frame_cnt    = fc_q;
    end

endmodule

// File: tb/tb_sync_pattern_gen.sv
// Scoreboard bench for sync_pattern_gen: expected per-tick bus words are queued
// when a configuration is applied and popped on every tus strobe.
module tb_sync_pattern_gen;

    localparam int CPT = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] cfg_frame_len = '0;
    logic [15:0] cfg_i_w = '0, cfg_ki_off = '0, cfg_ki_w = '0, cfg_p_off = '0, cfg_p_w = '0;
    logic [15:0] cfg_kp_off = '0, cfg_kp_w = '0, cfg_nc_w = '0, cfg_no_w = '0;
    logic [15:0] cfg_sec_frames = '0;
    logic        tus;
    logic [15:0] o;
    logic        busy;
    logic [31:0] frame_cnt;
`ifdef SYNC_FAULT_INJ_EN
    logic [1:0]  inj = '0;
`endif

    sync_pattern_gen #(.CLK_PER_TICK(CPT), .SEC_FRAMES_W(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_frame_len(cfg_frame_len), .cfg_i_w(cfg_i_w),
        .cfg_ki_off(cfg_ki_off), .cfg_ki_w(cfg_ki_w),
        .cfg_p_off(cfg_p_off), .cfg_p_w(cfg_p_w),
        .cfg_kp_off(cfg_kp_off), .cfg_kp_w(cfg_kp_w),
        .cfg_nc_w(cfg_nc_w), .cfg_sec_frames(cfg_sec_frames), .cfg_no_w(cfg_no_w),
`ifdef SYNC_FAULT_INJ_EN
        .inj(inj),
`endif
        .tus(tus), .o(o), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len, i_w, ki_off, ki_w, p_off, p_w, kp_off, kp_w, nc_w, sec, no_w;
    } tcfg_t;

    typedef struct {
        logic [15:0] o;
        logic [31:0] fc;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic bit inwin(int t, int off, int w);
        return (longint'(t) >= longint'(off)) && (longint'(t) < longint'(off) + longint'(w));
    endfunction

    // Reference bus word for tick t of a frame (ticks only range over 0..len-1).
    function automatic logic [15:0] model_o(tcfg_t c, int t, bit tno, bit [1:0] fi);
        logic [15:0] r;
        r     = '0;
        r[15] = inwin(t, 0, c.i_w);
        r[13] = inwin(t, c.ki_off, c.ki_w);
        r[10] = inwin(t, c.p_off, c.p_w) | (fi[0] && (t < c.ki_off + c.ki_w));
        r[9]  = inwin(t, c.kp_off, c.kp_w);
        r[6]  = inwin(fi[1] ? (t % 4) : t, 0, c.nc_w);
        r[5]  = tno && inwin(t, 0, c.no_w);
        return r;
    endfunction

    task automatic push_frames(input tcfg_t c, input int nfr, input int fc0, input int div0,
                               input bit [1:0] fi);
        int   len, sec;
        exp_t e;
        len = (c.len < 2) ? 2 : c.len;
        sec = (c.sec == 0) ? 1 : c.sec;
        for (int f = 0; f < nfr; f++) begin
            for (int t = 0; t < len; t++) begin
                e.o    = model_o(c, t, ((div0 + f) % sec) == 0, fi);
                e.fc   = 32'(fc0 + f);
                e.busy = 1'b1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic apply(input tcfg_t c);
        cfg_frame_len  = 32'(c.len);
        cfg_i_w        = 16'(c.i_w);
        cfg_ki_off     = 16'(c.ki_off);
        cfg_ki_w       = 16'(c.ki_w);
        cfg_p_off      = 16'(c.p_off);
        cfg_p_w        = 16'(c.p_w);
        cfg_kp_off     = 16'(c.kp_off);
        cfg_kp_w       = 16'(c.kp_w);
        cfg_nc_w       = 16'(c.nc_w);
        cfg_sec_frames = 16'(c.sec);
        cfg_no_w       = 16'(c.no_w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_tus(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * CPT + 4; i++) begin
            @(posedge clk);
            #1;
            if (tus === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL tus_timeout: no tus within %0d clk", 2 * CPT + 4);
        end
    endtask

    task automatic test_reset();
        int cyc, ntus;
        bit ok, idle_bad;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({tus, busy, o, frame_cnt} !== 50'd0) begin
            n_err++;
            $display("FAIL reset_state: tus=%b busy=%b o=%h fc=%0d, want all 0", tus, busy, o, frame_cnt);
        end
        rst = 1'b0;
        wait_tus(ok);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (tus !== 1'b1 && cyc < 100);
        n_cmp++;
        if (cyc !== CPT) begin
            n_err++;
            $display("FAIL tus_period: got %0d clk, want %0d", cyc, CPT);
        end
        ntus = 0;
        idle_bad = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (tus === 1'b1) ntus++;
            if (o !== 16'h0 || busy !== 1'b0) idle_bad = 1'b1;
        end
        n_cmp++;
        if (ntus !== 4) begin
            n_err++;
            $display("FAIL tus_count: got %0d in 100 clk, want 4", ntus);
        end
        n_cmp++;
        if (idle_bad !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: o/busy active while en=0 (o=%h busy=%b), want 0", o, busy);
        end
    endtask

    task automatic test_basic();
        tcfg_t c;
        exp_t  e;
        bit    ok;
        do_reset();
        c = '{len:100, i_w:10, ki_off:40, ki_w:5, p_off:0, p_w:0, kp_off:60, kp_w:3,
              nc_w:1, sec:1, no_w:2};
        apply(c);
        en = 1'b1;
        push_frames(c, 2, 0, 0, 2'b00);
        for (int k = 0; k < 200; k++) begin
            wait_tus(ok);
            if (!ok) break;
            e = sb.pop_front();
            n_cmp++;
            if (o !== e.o || frame_cnt !== e.fc || busy !== e.busy) begin
                n_err++;
                $display("FAIL basic k=%0d: o=%h fc=%0d busy=%b, want o=%h fc=%0d busy=%b",
                         k, o, frame_cnt, busy, e.o, e.fc, e.busy);
            end
        end
    endtask

    task automatic test_truncate();
        tcfg_t c;
        exp_t  e;
        bit    ok;
        do_reset();
        c = '{len:100, i_w:0, ki_off:120, ki_w:5, p_off:95, p_w:20, kp_off:0, kp_w:0,
              nc_w:0, sec:1, no_w:0};
        apply(c);
        en = 1'b1;
        push_frames(c, 2, 0, 0, 2'b00);
        for (int k = 0; k < 200; k++) begin
            wait_tus(ok);
            if (!ok) break;
            e = sb.pop_front();
            n_cmp++;
            if (o !== e.o || frame_cnt !== e.fc || busy !== e.busy) begin
                n_err++;
                $display("FAIL truncate k=%0d: o=%h fc=%0d busy=%b, want o=%h fc=%0d busy=%b",
                         k, o, frame_cnt, busy, e.o, e.fc, e.busy);
            end
        end
        // frame_len 1 is clamped to 2 ticks
        do_reset();
        c = '{len:1, i_w:1, ki_off:1, ki_w:5, p_off:0, p_w:0, kp_off:0, kp_w:0,
              nc_w:0, sec:1, no_w:0};
        apply(c);
        en = 1'b1;
        push_frames(c, 5, 0, 0, 2'b00);
        for (int k = 0; k < 10; k++) begin
            wait_tus(ok);
            if (!ok) break;
            e = sb.pop_front();
            n_cmp++;
            if (o !== e.o || frame_cnt !== e.fc || busy !== e.busy) begin
                n_err++;
                $display("FAIL clamp k=%0d: o=%h fc=%0d busy=%b, want o=%h fc=%0d busy=%b",
                         k, o, frame_cnt, busy, e.o, e.fc, e.busy);
            end
        end
    endtask

    task automatic test_tno();
        tcfg_t c;
        exp_t  e;
        bit    ok;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            c = '{len:10, i_w:0, ki_off:0, ki_w:0, p_off:0, p_w:0, kp_off:0, kp_w:0,
                  nc_w:0, sec:(pass == 0) ? 4 : 0, no_w:2};
            apply(c);
            en = 1'b1;
            push_frames(c, (pass == 0) ? 10 : 3, 0, 0, 2'b00);
            for (int k = 0; k < ((pass == 0) ? 100 : 30); k++) begin
                wait_tus(ok);
                if (!ok) break;
                e = sb.pop_front();
                n_cmp++;
                if (o !== e.o || frame_cnt !== e.fc || busy !== e.busy) begin
                    n_err++;
                    $display("FAIL tno sec=%0d k=%0d: o=%h fc=%0d, want o=%h fc=%0d",
                             c.sec, k, o, frame_cnt, e.o, e.fc);
                end
            end
        end
    endtask

    task automatic test_shadow_stop();
        tcfg_t c, c2;
        exp_t  e;
        bit    ok;
        do_reset();
        c = '{len:100, i_w:10, ki_off:0, ki_w:0, p_off:0, p_w:0, kp_off:0, kp_w:0,
              nc_w:0, sec:1, no_w:0};
        apply(c);
        en = 1'b1;
        c2 = c;
        c2.i_w = 30;
        push_frames(c, 1, 0, 0, 2'b00);
        push_frames(c2, 1, 1, 1, 2'b00);
        e = '{o:16'h0, fc:32'd2, busy:1'b0};
        repeat (3) sb.push_back(e);
        for (int k = 0; k < 203; k++) begin
            wait_tus(ok);
            if (!ok) break;
            e = sb.pop_front();
            n_cmp++;
            if (o !== e.o || frame_cnt !== e.fc || busy !== e.busy) begin
                n_err++;
                $display("FAIL shadow_stop k=%0d: o=%h fc=%0d busy=%b, want o=%h fc=%0d busy=%b",
                         k, o, frame_cnt, busy, e.o, e.fc, e.busy);
            end
            if (k == 5)   cfg_i_w = 16'd30;
            if (k == 150) en = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        tcfg_t c;
        exp_t  e;
        bit    ok;
        do_reset();
        c = '{len:30, i_w:25, ki_off:0, ki_w:0, p_off:0, p_w:0, kp_off:0, kp_w:0,
              nc_w:0, sec:1, no_w:0};
        apply(c);
        en = 1'b1;
        push_frames(c, 2, 0, 0, 2'b00);
        for (int k = 0; k < 51; k++) begin
            wait_tus(ok);
            if (!ok) break;
            e = sb.pop_front();
            n_cmp++;
            if (o !== e.o || frame_cnt !== e.fc || busy !== e.busy) begin
                n_err++;
                $display("FAIL midframe k=%0d: o=%h fc=%0d busy=%b, want o=%h fc=%0d busy=%b",
                         k, o, frame_cnt, busy, e.o, e.fc, e.busy);
            end
        end
        sb.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (o !== 16'h0 || frame_cnt !== 32'd0 || busy !== 1'b0 || tus !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_rst: o=%h fc=%0d busy=%b tus=%b, want all 0",
                     o, frame_cnt, busy, tus);
        end
        rst = 1'b0;
        en  = 1'b0;
    endtask

`ifdef SYNC_FAULT_INJ_EN
    task automatic test_inject();
        tcfg_t c;
        exp_t  e;
        bit    ok;
        do_reset();
        c = '{len:100, i_w:10, ki_off:40, ki_w:5, p_off:0, p_w:0, kp_off:0, kp_w:0,
              nc_w:1, sec:1, no_w:0};
        apply(c);
        inj = 2'b01;
        en  = 1'b1;
        push_frames(c, 1, 0, 0, 2'b01);
        push_frames(c, 1, 1, 1, 2'b11);
        for (int k = 0; k < 200; k++) begin
            wait_tus(ok);
            if (!ok) break;
            e = sb.pop_front();
            n_cmp++;
            if (o !== e.o || frame_cnt !== e.fc || busy !== e.busy) begin
                n_err++;
                $display("FAIL inject k=%0d: o=%h fc=%0d, want o=%h fc=%0d",
                         k, o, frame_cnt, e.o, e.fc);
            end
            if (k == 3) inj = 2'b11;
        end
        inj = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_tno();
        test_shadow_stop();
        test_reset_midframe();
`ifdef SYNC_FAULT_INJ_EN
        test_inject();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
